// File: rtl/sd_pkg.sv
// Shared definitions for the serial pattern transmitter and the pattern detectors.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sd_state_e;

  localparam int SD_MAX_LEN = 8;

  // Width of a length field able to hold 0..max_len.
  function automatic int sd_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sd_pattern_tx_if.sv
// Request/serial-output bundle of the pattern transmitter.
interface sd_pattern_tx_if import sd_pkg::*; #(
  parameter int MAX_LEN = SD_MAX_LEN
) ();
  localparam int LEN_W = sd_len_w(MAX_LEN);

  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [3:0]         repeat_n;
  logic               abort;
  logic               dout;
  logic               dout_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, pattern, len, repeat_n, abort,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, repeat_n, abort,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/sd1011_mealy.sv
// Overlapping "1011" sequence detector; hit is asserted while the final 1 is on din.
module sd1011_mealy (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  output logic hit
);

  typedef enum logic [1:0] {S0, S1, S10, S101} det_state_e;

  det_state_e st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S0;
    end else if (en) begin
      case (st)
        S0:      st <= din ? S1   : S0;
        S1:      st <= din ? S1   : S10;
        S10:     st <= din ? S101 : S0;
        S101:    st <= din ? S1   : S10;
        default: st <= S0;
      endcase
    end
  end

  assign hit = en && din && (st == S101);

endmodule

// File: rtl/sd_down_counter.sv
// Loadable down-counter that holds at zero; load wins over decrement.
module sd_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sd_pattern_tx.sv
// MSB-first serial pattern transmitter with repeat count, idle gap between frames and abort.
module sd_pattern_tx import sd_pkg::*; #(
  parameter int MAX_LEN    = SD_MAX_LEN,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  sd_pattern_tx_if.slave   bus
);

  localparam int               LEN_W    = sd_len_w(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  sd_state_e          state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [3:0]         reps_q;
  logic               done_q;

  logic [LEN_W-1:0]   bit_idx;
  logic [LEN_W-1:0]   bit_val;
  logic               bit_zero, bit_load, bit_en;
  logic [3:0]         gap_cnt;
  logic               gap_zero, gap_load, gap_en;
  logic               accept;
  logic [MAX_LEN-1:0] pat_shift;

  // Counter steering: a legal start loads the first bit index, frame ends reload or enter the gap.
  always_comb begin
    accept   = (state == IDLE) && bus.start && !bus.abort &&
               (bus.len != '0) && (bus.len <= LEN_MAX);
    bit_load = 1'b0;
    bit_en   = 1'b0;
    bit_val  = len_q - 1'b1;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    if (accept) begin
      bit_load = 1'b1;
      bit_val  = bus.len - 1'b1;
    end else if ((state == SEND) && !bus.abort) begin
      if (!bit_zero) begin
        bit_en = 1'b1;
      end else if (reps_q != 4'd0) begin
        if (GAP_CYCLES == 0) bit_load = 1'b1;
        else                 gap_load = 1'b1;
      end
    end else if ((state == GAP) && !bus.abort) begin
      if (gap_zero) bit_load = 1'b1;
      else          gap_en   = 1'b1;
    end
  end

  sd_down_counter #(.W(LEN_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (bit_load),
    .value (bit_val),
    .en    (bit_en),
    .count (bit_idx),
    .zero  (bit_zero)
  );

  sd_down_counter #(.W(4)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (gap_load),
    .value (GAP_LOAD),
    .en    (gap_en),
    .count (gap_cnt),
    .zero  (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      len_q  <= '0;
      reps_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pat_q  <= bus.pattern;
            len_q  <= bus.len;
            reps_q <= bus.repeat_n;
            state  <= SEND;
          end
        end
        SEND: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bit_zero) begin
            if (reps_q != 4'd0) begin
              reps_q <= reps_q - 4'd1;
              state  <= (GAP_CYCLES == 0) ? SEND : GAP;
            end else begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (bus.abort)     state <= IDLE;
          else if (gap_zero) state <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so no input reaches them combinationally.
  assign pat_shift      = pat_q >> bit_idx;
  assign bus.dout       = (state == SEND) && pat_shift[0];
  assign bus.dout_valid = (state == SEND);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;

endmodule
